// File: rtl/mem_if_ctrl.sv
// rtl/mem_if_ctrl.sv - single-beat bus to four byte-lane data memory controller
// Fans a 32-bit request out to four 16384x8 lanes and returns a one-cycle ack or err.
module mem_if_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [13:0] mem_adr,
  output logic [3:0]  mem_en,
  output logic        mem_we,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, ERR} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        req;
  logic        bad_req;
  logic        last;
  logic [31:0] lane_mask;

  assign req     = cyc_i & stb_i;
  assign bad_req = (adr_i[31:16] != 16'h0000) || (sel_i == 4'h0);
  assign last    = (cnt == 4'd0);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{sel_q[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = bad_req ? ERR : ACCESS;
      ACCESS: begin
        if (!cyc_i)    state_nxt = IDLE;
        else if (last) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes hold the lanes off until the last wait cycle so each byte is written once;
  // cyc_i gates the strobe so an abort in that cycle never reaches the macros.
  always_comb begin
    ack_o  = 1'b0;
    err_o  = 1'b0;
    mem_en = 4'h0;
    mem_we = 1'b0;
    case (state)
      ACCESS: begin
        if (cyc_i && (!we_q || last)) begin
          mem_en = sel_q;
          mem_we = we_q;
        end
      end
      ACK:     ack_o = 1'b1;
      ERR:     err_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      sel_q     <= 4'h0;
      we_q      <= 1'b0;
      mem_adr   <= 14'd0;
      mem_dat_o <= 32'd0;
      dat_o     <= 32'd0;
    end else begin
      if (state == IDLE && req) begin
        cnt       <= WAIT_CYCLES[3:0];
        sel_q     <= sel_i;
        we_q      <= we_i;
        mem_adr   <= adr_i[15:2];
        mem_dat_o <= dat_i;
      end else if (state == ACCESS && !last) begin
        cnt <= cnt - 4'd1;
      end
      // Unselected lanes float, so their bytes are forced to zero.
      if (state == ACCESS && cyc_i && last && !we_q) begin
        dat_o <= mem_dat_i & lane_mask;
      end
    end
  end

endmodule

// File: tb/tb_mem_if_ctrl.sv
// tb/tb_mem_if_ctrl.sv - randomized self-checking bench for mem_if_ctrl at 0, 2 and 3 wait cycles
// Each instance has its own lane memories; a word-level reference memory predicts results.
module tb_mem_if_ctrl;

  localparam int NI = 3;

  logic        clk;
  logic        rst;
  logic        cyc   [NI];
  logic        stb   [NI];
  logic        we    [NI];
  logic [31:0] adr   [NI];
  logic [3:0]  sel   [NI];
  logic [31:0] dat_w [NI];
  logic [31:0] dat_r [NI];
  logic        ack   [NI];
  logic        err   [NI];
  logic [13:0] madr  [NI];
  logic [3:0]  men   [NI];
  logic        mwe   [NI];
  logic [31:0] mdo   [NI];
  logic [31:0] mdi   [NI];

  logic [7:0]  lmem    [NI][4][16384];
  logic [31:0] ref_mem [NI][16384];
  logic [31:0] last_dat [NI];
  logic [31:0] junk;

  int n_checks;
  int n_errors;

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int n = 0; n < 4; n++) m[8*n +: 8] = s[n] ? 8'hFF : 8'h00;
    return m;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_if_ctrl #(.WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 2 : 3))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cyc_i     (cyc[g]),
      .stb_i     (stb[g]),
      .we_i      (we[g]),
      .adr_i     (adr[g]),
      .sel_i     (sel[g]),
      .dat_i     (dat_w[g]),
      .dat_o     (dat_r[g]),
      .ack_o     (ack[g]),
      .err_o     (err[g]),
      .mem_adr   (madr[g]),
      .mem_en    (men[g]),
      .mem_we    (mwe[g]),
      .mem_dat_o (mdo[g]),
      .mem_dat_i (mdi[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane macros: synchronous write, combinational read, junk on disabled lanes.
  always @(posedge clk) begin
    junk <= $urandom;
    for (int k = 0; k < NI; k++)
      for (int n = 0; n < 4; n++)
        if (mwe[k] && men[k][n]) lmem[k][n][madr[k]] <= mdo[k][8*n +: 8];
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      mdi[k] = junk;
      for (int n = 0; n < 4; n++)
        if (men[k][n]) mdi[k][8*n +: 8] = lmem[k][n][madr[k]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int abort_c);
    int          wk;
    logic        ok;
    logic        aborted;
    int          ack_c, err_c, n_ack, n_err, n_stb, stb_c, en_cyc;
    logic [3:0]  stb_en;
    logic [31:0] rd;
    logic        both, addr_bad;
    logic [31:0] exp_rd;
    wk       = wc(k);
    ok       = (a[31:16] == 16'h0) && (s != 4'h0);
    aborted  = ok && (abort_c != 0) && (abort_c <= wk + 1);
    ack_c = 0; err_c = 0; n_ack = 0; n_err = 0; n_stb = 0; stb_c = 0; en_cyc = 0;
    stb_en = 4'h0; rd = 32'h0; both = 1'b0; addr_bad = 1'b0;
    exp_rd = ref_mem[k][a[15:2]] & bmask(s);

    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat_w[k] = d;
    @(posedge clk);
    #1;
    stb[k] = 1'b0; adr[k] = $urandom; dat_w[k] = $urandom; sel[k] = 4'($urandom);
    for (int c = 1; c <= wk + 4; c++) begin
      @(negedge clk);
      if (c == abort_c) cyc[k] = 1'b0;
      #1;
      if (ack[k]) begin
        n_ack++;
        if (ack_c == 0) begin ack_c = c; rd = dat_r[k]; end
      end
      if (err[k]) begin
        n_err++;
        if (err_c == 0) err_c = c;
      end
      if (ack[k] && err[k]) both = 1'b1;
      if (men[k] != 4'h0) en_cyc++;
      if (mwe[k]) begin n_stb++; stb_c = c; stb_en = men[k]; end
      if (ok && c <= wk + 1 && (abort_c == 0 || c < abort_c))
        if (madr[k] != a[15:2] || mdo[k] != d) addr_bad = 1'b1;
    end
    cyc[k] = 1'b0;

    check("ack_err_overlap", 32'(both), 32'd0);
    if (!ok) begin
      check("err_cycle", 32'(err_c), 32'd1);
      check("err_count", 32'(n_err), 32'd1);
      check("err_no_ack", 32'(n_ack), 32'd0);
      check("err_no_lane", 32'(en_cyc + n_stb), 32'd0);
    end else if (aborted) begin
      check("abort_no_ack", 32'(n_ack + n_err), 32'd0);
      check("abort_no_write", 32'(n_stb), 32'd0);
      check("abort_adr_hold", 32'(addr_bad), 32'd0);
    end else begin
      check("ack_cycle", 32'(ack_c), 32'(wk + 2));
      check("ack_count", 32'(n_ack), 32'd1);
      check("no_err", 32'(n_err), 32'd0);
      check("adr_hold", 32'(addr_bad), 32'd0);
      if (w) begin
        check("wr_strobes", 32'(n_stb), 32'd1);
        check("wr_strobe_cycle", 32'(stb_c), 32'(wk + 1));
        check("wr_strobe_en", 32'(stb_en), 32'(s));
        check("wr_en_cycles", 32'(en_cyc), 32'd1);
        for (int n = 0; n < 4; n++)
          if (s[n]) ref_mem[k][a[15:2]][8*n +: 8] = d[8*n +: 8];
      end else begin
        check("rd_no_strobe", 32'(n_stb), 32'd0);
        check("rd_en_cycles", 32'(en_cyc), 32'(wk + 1));
        check("rd_data", rd, exp_rd);
        last_dat[k] = exp_rd;
      end
    end
    check("dat_o_hold", dat_r[k], last_dat[k]);
  endtask

  task automatic check_outs_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      check({tag, "_dat_o"}, dat_r[k], 32'h0);
      check({tag, "_mem_dat_o"}, mdo[k], 32'h0);
      check({tag, "_ctl"}, {11'h0, ack[k], err[k], mwe[k], men[k], madr[k]}, 32'h0);
    end
  endtask

  task automatic rst_mid_read(input int k, input logic [31:0] a);
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0; adr[k] = a; sel[k] = 4'hF;
    @(posedge clk);
    #1;
    stb[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs_zero("rst_mid");
    @(negedge clk);
    #1;
    check_outs_zero("rst_hold");
    cyc[k] = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) last_dat[i] = 32'h0;
  endtask

  logic [31:0] pool [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    pool = '{32'h100, 32'h200, 32'h0, 32'hFFFC, 32'h1234, 32'h8000, 32'h4444, 32'hABC0};
    for (int k = 0; k < NI; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; adr[k] = 32'h0;
      sel[k] = 4'h0; dat_w[k] = 32'h0; last_dat[k] = 32'h0;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outs_zero("reset");
    rst = 1'b1;

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 8; i++) xfer(k, 1'b1, pool[i], 4'hF, $urandom, 0);

    xfer(0, 1'b1, 32'h0000_0100, 4'hF, 32'hDEADBEEF, 0);
    xfer(0, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 0);
    xfer(0, 1'b1, 32'h0000_0200, 4'hF, 32'h11223344, 0);
    xfer(0, 1'b1, 32'h0000_0200, 4'h5, 32'hAABBCCDD, 0);
    xfer(0, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 0);
    xfer(0, 1'b1, 32'h0000_0200, 4'h2, 32'h0000CC00, 0);
    xfer(0, 1'b0, 32'h0000_0200, 4'h2, 32'h0, 0);
    xfer(0, 1'b1, 32'h0001_0100, 4'hF, 32'h12345678, 0);
    xfer(0, 1'b1, 32'h0000_0100, 4'h0, 32'h12345678, 0);
    xfer(0, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 0);
    xfer(2, 1'b1, 32'h0000_0104, 4'hF, 32'hCAFEF00D, 0);
    xfer(2, 1'b0, 32'h0000_0104, 4'hF, 32'h0, 0);
    xfer(1, 1'b1, 32'h0000_0100, 4'hF, 32'h55AA55AA, 1);
    xfer(1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 0);
    xfer(1, 1'b1, 32'h0000_0100, 4'hF, 32'h66BB66BB, 3);
    xfer(1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 0);
    rst_mid_read(2, 32'h0000_0104);
    xfer(2, 1'b0, 32'h0000_0104, 4'hF, 32'h0, 0);

    for (int it = 0; it < 60; it++) begin
      int          k;
      int          ab;
      logic [31:0] a;
      k = $urandom_range(0, NI - 1);
      a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 65535)) << 16);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, wc(k) + 1) : 0;
      xfer(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, ab);
    end

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 8; i++) xfer(k, 1'b0, pool[i], 4'hF, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
